// File: rtl/display_pkg.sv
// Shared constants, FSM state type and glyph ROM contents for the multi-digit
// seven-segment-style sprite display.
package display_pkg;

  localparam int DIGIT_W      = 20;
  localparam int DIGIT_H      = 30;
  localparam int SPRITE_BYTES = 600;
  localparam int SPRITE_AW    = 13;
  localparam string SPRITE_FILE = "mem/digit_sprites.mem";

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } conv_state_e;

  // Glyph ROM contents: ten 20x30 sprites stacked at SPRITE_BYTES stride.
  function automatic logic [5:0] sprite_rgb(input logic [SPRITE_AW-1:0] addr);
    return addr[5:0] ^ addr[11:6] ^ {5'd0, addr[12]};
  endfunction

  function automatic int unsigned pow10(input int n);
    int unsigned p;
    p = 32'd1;
    for (int k = 0; k < n; k++) begin
      p = p * 32'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, MSB first, one bit per
// cycle) with start/busy/done handshake and out-of-range detection.
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int VALUE_W    = 10,
  parameter int NUM_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [VALUE_W-1:0]      bin,
  output logic                    busy,
  output logic                    done,
  output logic                    ovf,
  output logic [NUM_DIGITS*4-1:0] bcd
);
  localparam int CNT_W = $clog2(VALUE_W) + 1;
  localparam logic [31:0] MAX_VAL = 32'(pow10(NUM_DIGITS) - 32'd1);

  conv_state_e             state_q;
  logic [VALUE_W-1:0]      shift_q;
  logic [NUM_DIGITS*4-1:0] bcd_q;
  logic [NUM_DIGITS*4-1:0] bcd_d;
  logic [CNT_W-1:0]        cnt_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    ovf_q;

  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign bcd  = bcd_q;

  // One double-dabble step: add 3 to every digit >= 5, then shift in next bit
  always_comb begin
    bcd_d = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_d[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end else begin
        bcd_d[i*4 +: 4] = bcd_q[i*4 +: 4];
      end
    end
    bcd_d = {bcd_d[NUM_DIGITS*4-2:0], shift_q[VALUE_W-1]};
  end

  // Conversion FSM; done is high for the single COMMIT cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= CONVERT;
            busy_q  <= 1'b1;
            shift_q <= bin;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= (32'(bin) > MAX_VAL);
          end
        end
        CONVERT: begin
          bcd_q   <= bcd_d;
          shift_q <= shift_q << 1;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(VALUE_W - 1)) begin
            state_q <= COMMIT;
            done_q  <= 1'b1;
          end
        end
        COMMIT: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/n_digit_display.sv
// N-digit decimal sprite display: captures a binary value, converts it to BCD
// in the background and renders the committed digits with blanking and blink.
module n_digit_display
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 3,
  parameter int VALUE_W      = 10,
  parameter int X0           = 0,
  parameter int Y0           = 0,
  parameter int BLINK_FRAMES = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         col,
  input  logic [9:0]         row,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  input  logic               blank_lz,
  input  logic               blink_en,
  input  logic               frame_tick,
  output logic               busy,
  output logic               overflow,
  output logic               on,
  output logic [5:0]         rgb
);
  localparam int BC_W = $clog2(BLINK_FRAMES + 1);

  logic [VALUE_W-1:0]         value_q;
  logic                       start_q;
  logic [NUM_DIGITS-1:0][3:0] disp_q;
  logic                       overflow_q;
  logic [BC_W-1:0]            blink_cnt_q;
  logic                       hidden_q;
  logic                       on_q;
  logic [5:0]                 rgb_q;
  logic                       conv_busy_s;
  logic                       conv_done_s;
  logic                       conv_ovf_s;
  logic [NUM_DIGITS*4-1:0]    conv_bcd_s;
  logic [10:0]                rel_x_s;
  logic [10:0]                rel_y_s;
  logic [10:0]                off_s;
  logic [NUM_DIGITS-1:0]      lz_s;
  logic                       zero_run_s;
  logic                       in_box_s;
  logic                       blank_s;
  logic [3:0]                 digit_s;
  logic [4:0]                 px_s;
  logic [SPRITE_AW-1:0]       addr_s;
  logic                       on_d;
  logic [5:0]                 rgb_d;

  bin2bcd_seq #(
    .VALUE_W    (VALUE_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (start_q),
    .bin   (value_q),
    .busy  (conv_busy_s),
    .done  (conv_done_s),
    .ovf   (conv_ovf_s),
    .bcd   (conv_bcd_s)
  );

  assign busy     = start_q | conv_busy_s;
  assign overflow = overflow_q;
  assign on       = on_q;
  assign rgb      = rgb_q;
  // Wrap-around subtraction: pixels left of/above the origin become huge
  assign rel_x_s  = {1'b0, col} - 11'(X0);
  assign rel_y_s  = {1'b0, row} - 11'(Y0);

  // Load capture and atomic digit commit; loads while busy are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q    <= '0;
      start_q    <= 1'b0;
      disp_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      start_q <= load && !busy;
      if (load && !busy) begin
        value_q <= value;
      end
      if (conv_done_s) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          disp_q[i] <= conv_ovf_s ? 4'd9 : conv_bcd_s[(NUM_DIGITS-1-i)*4 +: 4];
        end
        overflow_q <= conv_ovf_s;
      end
    end
  end

  // Blink phase: toggles every BLINK_FRAMES frame ticks while enabled
  always_ff @(posedge clk) begin
    if (rst || !blink_en) begin
      blink_cnt_q <= '0;
      hidden_q    <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt_q == BC_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_q <= '0;
        hidden_q    <= !hidden_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BC_W'(1);
      end
    end
  end

  // Leading-zero mask; the rightmost digit always stays visible
  always_comb begin
    zero_run_s = 1'b1;
    lz_s       = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      zero_run_s = zero_run_s && (disp_q[i] == 4'd0);
      lz_s[i]    = blank_lz && zero_run_s && (i != NUM_DIGITS - 1);
    end
  end

  // Digit box hit test and shared sprite ROM lookup
  always_comb begin
    off_s    = '0;
    in_box_s = 1'b0;
    digit_s  = 4'd0;
    px_s     = 5'd0;
    blank_s  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      off_s = rel_x_s - 11'(DIGIT_W * i);
      if (off_s < 11'(DIGIT_W) && rel_y_s < 11'(DIGIT_H)) begin
        in_box_s = 1'b1;
        digit_s  = disp_q[i];
        px_s     = off_s[4:0];
        blank_s  = lz_s[i];
      end else begin
        in_box_s = in_box_s;
      end
    end
    addr_s = 13'(digit_s) * 13'(SPRITE_BYTES) + 13'(rel_y_s) * 13'(DIGIT_W) + 13'(px_s);
    on_d   = in_box_s && !blank_s && !hidden_q;
    rgb_d  = on_d ? sprite_rgb(addr_s) : 6'd0;
  end

  // Registered pixel outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      on_q  <= 1'b0;
      rgb_q <= 6'd0;
    end else begin
      on_q  <= on_d;
      rgb_q <= rgb_d;
    end
  end

endmodule

// File: tb/tb_n_digit_display.sv
// Scoreboard bench for n_digit_display: stimulus queues expected pixels and
// conversion results; a negedge monitor pops and compares them.
module tb_n_digit_display;
  localparam int ND = 3;
  localparam int VW = 10;
  localparam int X0 = 100;
  localparam int Y0 = 40;
  localparam int BF = 2;

  typedef struct {
    string    name;
    bit       on;
    bit [5:0] rgb;
  } pix_exp_t;

  typedef struct {
    string name;
    int    cycles;
    bit    ovf;
  } commit_exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [9:0]    col = 10'd0;
  logic [9:0]    row = 10'd0;
  logic [VW-1:0] value = '0;
  logic          load = 1'b0;
  logic          blank_lz = 1'b0;
  logic          blink_en = 1'b0;
  logic          frame_tick = 1'b0;
  logic          busy;
  logic          overflow;
  logic          on;
  logic [5:0]    rgb;

  pix_exp_t    pix_q[$];
  commit_exp_t commit_q[$];
  bit          px_req = 1'b0;
  bit          px_req_d = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          busy_cnt = 0;
  bit          busy_prev = 1'b0;

  n_digit_display #(
    .NUM_DIGITS   (ND),
    .VALUE_W      (VW),
    .X0           (X0),
    .Y0           (Y0),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .col        (col),
    .row        (row),
    .value      (value),
    .load       (load),
    .blank_lz   (blank_lz),
    .blink_en   (blink_en),
    .frame_tick (frame_tick),
    .busy       (busy),
    .overflow   (overflow),
    .on         (on),
    .rgb        (rgb)
  );

  always #5 clk = ~clk;

  function automatic bit [5:0] rom_rgb(input int addr);
    bit [12:0] a;
    a = 13'(addr);
    return a[5:0] ^ a[11:6] ^ {5'd0, a[12]};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input string name, input int pos, input int d, input bit vis,
                       input int dx, input int dy);
    pix_exp_t e;
    col    = 10'(X0 + 20 * pos + dx);
    row    = 10'(Y0 + dy);
    e.name = name;
    e.on   = vis;
    e.rgb  = vis ? rom_rgb(d * 600 + dy * 20 + dx) : 6'd0;
    pix_q.push_back(e);
    px_req = 1'b1;
    step();
    px_req = 1'b0;
  endtask

  task automatic probe_off(input string name, input int c, input int r);
    pix_exp_t e;
    col    = 10'(c);
    row    = 10'(r);
    e.name = name;
    e.on   = 1'b0;
    e.rgb  = 6'd0;
    pix_q.push_back(e);
    px_req = 1'b1;
    step();
    px_req = 1'b0;
  endtask

  task automatic probe_digits(input string name, input int d0, input int d1, input int d2,
                              input bit v0, input bit v1, input bit v2);
    probe({name, "_d0"}, 0, d0, v0, 3, 5);
    probe({name, "_d1"}, 1, d1, v1, 10, 15);
    probe({name, "_d2"}, 2, d2, v2, 17, 26);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    if (busy) check({name, "_timeout"}, 1, 0);
  endtask

  task automatic do_load(input string name, input int v, input bit ovf);
    commit_exp_t ce;
    ce.name   = name;
    ce.cycles = VW + 2;
    ce.ovf    = ovf;
    commit_q.push_back(ce);
    value = VW'(v);
    load  = 1'b1;
    step();
    load = 1'b0;
    wait_idle(name);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      px_req_d = px_req;
    end
  end

  // Monitor: conversion results on busy falling edge, pixels one cycle after request
  initial begin
    commit_exp_t ce;
    pix_exp_t    pe;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt  = 0;
        busy_prev = 1'b0;
      end else begin
        if (busy) begin
          busy_cnt++;
        end else if (busy_prev) begin
          if (commit_q.size() == 0) begin
            check("unexpected_commit", busy_cnt, 0);
          end else begin
            ce = commit_q.pop_front();
            check({ce.name, "_busy_cycles"}, busy_cnt, ce.cycles);
            check({ce.name, "_overflow"}, int'(overflow), int'(ce.ovf));
          end
          busy_cnt = 0;
        end
        busy_prev = busy;
      end
      if (px_req_d) begin
        if (pix_q.size() == 0) begin
          check("unexpected_pixel", 1, 0);
        end else begin
          pe = pix_q.pop_front();
          check({pe.name, "_on"}, int'(on), int'(pe.on));
          check({pe.name, "_rgb"}, int'(rgb), int'(pe.rgb));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    step();
    step();
    check("rst_busy", int'(busy), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_on", int'(on), 0);
    check("rst_rgb", int'(rgb), 0);
    rst = 1'b0;
    probe_digits("after_rst", 0, 0, 0, 1'b1, 1'b1, 1'b1);

    do_load("v427", 427, 1'b0);
    probe_digits("v427", 4, 2, 7, 1'b1, 1'b1, 1'b1);
    probe("v427_corner", 2, 7, 1'b1, 19, 29);
    probe("v427_origin", 0, 4, 1'b1, 0, 0);
    probe_off("left_of_box", X0 - 1, Y0 + 5);
    probe_off("right_of_box", X0 + 60, Y0 + 5);
    probe_off("below_box", X0 + 5, Y0 + 30);
    probe_off("above_box", X0 + 5, Y0 - 1);

    do_load("v1000", 1000, 1'b1);
    probe_digits("v1000", 9, 9, 9, 1'b1, 1'b1, 1'b1);

    blank_lz = 1'b1;
    do_load("v7", 7, 1'b0);
    probe_digits("lz7", 0, 0, 7, 1'b0, 1'b0, 1'b1);
    do_load("v0", 0, 1'b0);
    probe_digits("lz0", 0, 0, 0, 1'b0, 1'b0, 1'b1);
    do_load("v50", 50, 1'b0);
    probe_digits("lz50", 0, 5, 0, 1'b0, 1'b1, 1'b1);
    blank_lz = 1'b0;

    begin
      commit_exp_t ce;
      ce.name   = "v123";
      ce.cycles = VW + 2;
      ce.ovf    = 1'b0;
      commit_q.push_back(ce);
    end
    value = VW'(123);
    load  = 1'b1;
    step();
    load = 1'b0;
    step();
    value = VW'(456);
    load  = 1'b1;
    step();
    load = 1'b0;
    wait_idle("v123");
    probe_digits("v123", 1, 2, 3, 1'b1, 1'b1, 1'b1);

    blink_en = 1'b1;
    step();
    for (int t = 1; t <= 4; t++) begin
      tick();
      probe($sformatf("blink_t%0d", t), 1, 2, (t == 1 || t == 4), 10, 15);
    end
    tick();
    tick();
    probe("blink_t6_hidden", 0, 1, 1'b0, 3, 5);
    blink_en = 1'b0;
    step();
    probe("blink_off_visible", 0, 1, 1'b1, 3, 5);
    blink_en = 1'b1;
    step();
    tick();
    probe("reenable_t1", 2, 3, 1'b1, 17, 26);
    tick();
    probe("reenable_t2", 2, 3, 1'b0, 17, 26);
    blink_en = 1'b0;
    step();

    col   = 10'(X0 + 30);
    row   = 10'(Y0 + 10);
    value = VW'(999);
    load  = 1'b1;
    step();
    load = 1'b0;
    repeat (4) step();
    check("mid_conv_busy", int'(busy), 1);
    rst   = 1'b1;
    load  = 1'b1;
    value = VW'(5);
    step();
    load = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_on", int'(on), 0);
    check("abort_rgb", int'(rgb), 0);
    check("abort_overflow", int'(overflow), 0);
    step();
    rst = 1'b0;
    repeat (20) step();
    check("abort_stays_idle", int'(busy), 0);
    probe_digits("after_abort", 0, 0, 0, 1'b1, 1'b1, 1'b1);

    repeat (3) step();
    check("pix_queue_drained", pix_q.size(), 0);
    check("commit_queue_drained", commit_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/n_digit_display.md
N_DIGIT_DISPLAY -- requirements
Module: n_digit_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 3, number of decimal digits shown (1..6).
REQ-002 SHALL have parameter VALUE_W, default 10, width of the binary value input (1..20).
REQ-003 SHALL have parameters X0/Y0, default 0/0, top-left pixel of the leftmost digit.
REQ-004 SHALL have parameter BLINK_FRAMES, default 30, frame_tick count per blink half-period.
REQ-005 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports col, row, input, 10 each, current pixel coordinates.
REQ-008 SHALL have port value, input, VALUE_W, unsigned binary value to display.
REQ-009 SHALL have port load, input, 1, one-cycle request to capture value.
REQ-010 SHALL have port blank_lz, input, 1, leading-zero blanking enable.
REQ-011 SHALL have port blink_en, input, 1, blink enable.
REQ-012 SHALL have port frame_tick, input, 1, one-cycle pulse per video frame.
REQ-013 SHALL have port busy, output, 1, conversion in progress.
REQ-014 SHALL have port overflow, output, 1, last loaded value exceeded 10^NUM_DIGITS-1.
REQ-015 SHALL have ports on, output, 1, and rgb, output, 6, registered pixel outputs.

Function
REQ-016 SHALL use FSM states IDLE, CONVERT, COMMIT; IDLE->CONVERT on load, CONVERT->COMMIT after exactly VALUE_W shift cycles, COMMIT->IDLE after one cycle.
REQ-017 SHALL convert by sequential shift-add-3 (double dabble), one input bit per cycle, MSB first.
REQ-018 SHALL assert busy from the cycle after load through COMMIT inclusive; latency load-to-new-digits-visible = VALUE_W+2 cycles.
REQ-019 SHALL ignore load while busy=1; the in-flight conversion completes unchanged.
REQ-020 SHALL update all displayed digit registers atomically in COMMIT; displayed digits never show a partial result.
REQ-021 SHALL, when the captured value > 10^NUM_DIGITS-1, commit all digits as 9 and set overflow=1; otherwise commit overflow=0.
REQ-022 SHALL place digit i (0 = leftmost) at X0+20*i, Y0, 20x30 pixels; box test identical for every digit.
REQ-023 SHALL form sprite ROM address digit*600 + (row-Y0)*20 + (col-X0) and output ROM[5:0] as rgb.
REQ-024 SHALL, with blank_lz=1, force on=0 for every digit left of the most significant nonzero digit; the rightmost digit is never blanked (value 0 shows "0").
REQ-025 SHALL, with blink_en=1, count frame_tick pulses and toggle a visibility phase every BLINK_FRAMES ticks; phase hidden forces on=0 for all digits.
REQ-026 SHALL, with blink_en=0, hold the phase visible and the counter at 0; re-enabling starts in the visible phase.
REQ-027 SHALL register on and rgb: outputs reflect col/row of the previous cycle (latency 1).
REQ-028 SHALL drive rgb=0 whenever on=0.
REQ-029 SHALL assign coordinates outside every digit box on=0, rgb=0.

Reset
REQ-030 SHALL, with rst=1 at a clock edge, set state IDLE, busy=0, overflow=0, all displayed digits 0, blink counter 0, phase visible, on=0, rgb=0.
REQ-031 SHALL abort an in-flight conversion on rst; no COMMIT occurs and displayed digits read 0.
REQ-032 SHALL give rst priority over load in the same cycle.

Structure
REQ-033 SHALL place DIGIT_W=20, DIGIT_H=30, SPRITE_BYTES=600, the sprite memory file path and the FSM state enum in shared package display_pkg.
REQ-034 SHALL implement the conversion FSM in sub-module bin2bcd_seq (start/busy/done handshake, parametrised by VALUE_W and NUM_DIGITS).
REQ-035 SHALL share one sprite ROM across all digits, indexed by the digit selected from the column.

Verification
REQ-036 SHALL test: NUM_DIGITS=3, VALUE_W=10, load value=427 -> busy high 12 cycles, then digits 4,2,7, overflow=0.
REQ-037 SHALL test: load 1000 with NUM_DIGITS=3 -> digits 9,9,9, overflow=1.
REQ-038 SHALL test: blank_lz=1, load 7 -> pixels of digits 0,1 have on=0; digit 2 shows sprite 7; load 0 -> only "0" visible.
REQ-039 SHALL test: load 123, then load 456 two cycles later -> second load ignored, display 123.
REQ-040 SHALL test: blink_en=1, BLINK_FRAMES=2 -> on=0 after ticks 2-3, on restored after tick 4.
REQ-041 SHALL test: rst asserted mid-conversion of 999 -> busy=0 next cycle, digits 0,0,0, on/rgb=0 that cycle.
